// File: rtl/mul_operand_feeder.sv
// Operand-pair FIFO feeding two independent AXI-Stream channels (A and B) of a
// floating-point multiplier; the head pair pops only once both words are accepted.
`timescale 1ns/1ps

module mul_operand_feeder #(
  parameter int DEPTH = 4
) (
  input  logic        aclk,
  input  logic        areset,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_last,

  output logic        m_axis_a_tvalid,
  input  logic        m_axis_a_tready,
  output logic [31:0] m_axis_a_tdata,
  output logic        m_axis_a_tlast,

  output logic        m_axis_b_tvalid,
  input  logic        m_axis_b_tready,
  output logic [31:0] m_axis_b_tdata,
  output logic        m_axis_b_tlast,

  output logic [15:0] pair_count,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mul_operand_feeder: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  // Entry layout: {last, B, A}
  logic [64:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          a_done;
  logic          b_done;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          a_fire;
  logic          b_fire;
  logic [64:0]   head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready = !full;
  assign busy     = !empty;
  assign push     = in_valid && !full;

  assign head = mem[rd_ptr[AW-1:0]];

  assign m_axis_a_tvalid = !empty && !a_done;
  assign m_axis_b_tvalid = !empty && !b_done;

  // Data and last are forced to zero while empty so stale storage never shows.
  assign m_axis_a_tdata = empty ? 32'd0 : head[31:0];
  assign m_axis_b_tdata = empty ? 32'd0 : head[63:32];
  assign m_axis_a_tlast = !empty && head[64];
  assign m_axis_b_tlast = !empty && head[64];

  assign a_fire = m_axis_a_tvalid && m_axis_a_tready;
  assign b_fire = m_axis_b_tvalid && m_axis_b_tready;
  assign pop    = !empty && (a_done || a_fire) && (b_done || b_fire);

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_last, in_b, in_a};
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_ptr      <= '0;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      pair_count  <= 16'd0;
      frame_count <= 16'd0;
    end else if (pop) begin
      rd_ptr     <= rd_ptr + PTR_ONE;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      pair_count <= pair_count + 16'd1;
      if (head[64]) begin
        frame_count <= frame_count + 16'd1;
      end
    end else begin
      if (a_fire) a_done <= 1'b1;
      if (b_fire) b_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Randomized self-checking bench for mul_operand_feeder; the model tracks pushed
// pairs and per-channel accepted words, and derives the counters from them.
`timescale 1ns/1ps

module tb_mul_operand_feeder;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_last = 1'b0;
  logic        m_axis_a_tvalid, m_axis_a_tready = 1'b0, m_axis_a_tlast;
  logic [31:0] m_axis_a_tdata;
  logic        m_axis_b_tvalid, m_axis_b_tready = 1'b0, m_axis_b_tlast;
  logic [31:0] m_axis_b_tdata;
  logic [15:0] pair_count, frame_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mul_operand_feeder #(.DEPTH(4)) dut (
    .aclk(aclk), .areset(areset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .m_axis_a_tvalid(m_axis_a_tvalid), .m_axis_a_tready(m_axis_a_tready),
    .m_axis_a_tdata(m_axis_a_tdata), .m_axis_a_tlast(m_axis_a_tlast),
    .m_axis_b_tvalid(m_axis_b_tvalid), .m_axis_b_tready(m_axis_b_tready),
    .m_axis_b_tdata(m_axis_b_tdata), .m_axis_b_tlast(m_axis_b_tlast),
    .pair_count(pair_count), .frame_count(frame_count), .busy(busy)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reference model: every accepted pair in order, every word accepted per channel.
  logic [64:0] hist[$];
  logic [32:0] obs_a[$];
  logic [32:0] obs_b[$];
  int na, nb, npop, nframe;

  task automatic clear_model();
    hist.delete(); obs_a.delete(); obs_b.delete();
    na = 0; nb = 0; npop = 0; nframe = 0;
  endtask

  // Called at the sample point before a rising edge: logs what that edge will do.
  task automatic record();
    int m;
    if (in_valid && in_ready) hist.push_back({in_last, in_b, in_a});
    if (m_axis_a_tvalid && m_axis_a_tready) begin
      obs_a.push_back({m_axis_a_tlast, m_axis_a_tdata}); na++;
    end
    if (m_axis_b_tvalid && m_axis_b_tready) begin
      obs_b.push_back({m_axis_b_tlast, m_axis_b_tdata}); nb++;
    end
    m = (na < nb) ? na : nb;
    while (npop < m && npop < hist.size()) begin
      if (hist[npop][64]) nframe++;
      npop++;
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1; in_valid = 1'b0; m_axis_a_tready = 1'b0; m_axis_b_tready = 1'b0;
    clear_model();
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_last = 1'b1;
      #1 record();
      @(negedge aclk);
    end
    in_valid = 1'b0;
    @(posedge aclk); #2;
    areset = 1'b1;
    clear_model();
    #1;
    checks++; if (m_axis_a_tvalid !== 1'b0) begin errors++; $display("FAIL rst_a_tvalid got=%b exp=0", m_axis_a_tvalid); end
    checks++; if (m_axis_b_tvalid !== 1'b0) begin errors++; $display("FAIL rst_b_tvalid got=%b exp=0", m_axis_b_tvalid); end
    checks++; if ({m_axis_a_tlast, m_axis_b_tlast} !== 2'b00) begin errors++; $display("FAIL rst_tlast got=%b exp=00", {m_axis_a_tlast, m_axis_b_tlast}); end
    checks++; if ({m_axis_a_tdata, m_axis_b_tdata} !== 64'd0) begin errors++; $display("FAIL rst_tdata got=%h exp=0", {m_axis_a_tdata, m_axis_b_tdata}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if ({pair_count, frame_count} !== 32'd0) begin errors++; $display("FAIL rst_counts got=%h exp=0", {pair_count, frame_count}); end
    @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1;
    in_valid = 1'b1; in_a = 32'h3E9E377A; in_b = 32'h3E9E377A; in_last = 1'b1;
    #1 record();
    @(negedge aclk);
    in_valid = 1'b0;
    #1;
    checks++; if ({m_axis_a_tvalid, m_axis_b_tvalid} !== 2'b11) begin errors++; $display("FAIL lat_tvalid got=%b exp=11", {m_axis_a_tvalid, m_axis_b_tvalid}); end
    checks++; if (m_axis_a_tdata !== 32'h3E9E377A || m_axis_b_tdata !== 32'h3E9E377A) begin errors++; $display("FAIL lat_tdata got=%h/%h exp=3e9e377a", m_axis_a_tdata, m_axis_b_tdata); end
    checks++; if ({m_axis_a_tlast, m_axis_b_tlast} !== 2'b11) begin errors++; $display("FAIL lat_tlast got=%b exp=11", {m_axis_a_tlast, m_axis_b_tlast}); end
    record();
    @(negedge aclk); #1;
    checks++; if ({m_axis_a_tvalid, m_axis_b_tvalid} !== 2'b00) begin errors++; $display("FAIL lat_drop got=%b exp=00", {m_axis_a_tvalid, m_axis_b_tvalid}); end
    checks++; if (pair_count !== 16'd1 || frame_count !== 16'd1) begin errors++; $display("FAIL lat_counts got=%0d/%0d exp=1/1", pair_count, frame_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy got=%b exp=0", busy); end
  endtask

  task automatic test_skew();
    logic [31:0] bw;
    do_reset();
    bw = $urandom;
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b0;
    in_valid = 1'b1; in_a = $urandom; in_b = bw; in_last = 1'b0;
    #1 record();
    @(negedge aclk);
    in_valid = 1'b0;
    #1 record();
    @(negedge aclk);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (m_axis_a_tvalid !== 1'b0) begin errors++; $display("FAIL skew_a_drop cyc=%0d got=%b exp=0", i, m_axis_a_tvalid); end
      checks++; if (m_axis_b_tvalid !== 1'b1 || m_axis_b_tdata !== bw) begin errors++; $display("FAIL skew_b_hold cyc=%0d got=%b/%h exp=1/%h", i, m_axis_b_tvalid, m_axis_b_tdata, bw); end
      if (i == 2) m_axis_b_tready = 1'b1;
      record();
      @(negedge aclk);
    end
    #1;
    checks++; if (busy !== 1'b0 || m_axis_b_tvalid !== 1'b0) begin errors++; $display("FAIL skew_pop busy/b_tvalid got=%b%b exp=00", busy, m_axis_b_tvalid); end
    checks++; if (pair_count !== 16'd1 || frame_count !== 16'd0) begin errors++; $display("FAIL skew_counts got=%0d/%0d exp=1/0", pair_count, frame_count); end
    checks++; if (obs_a.size() != 1 || obs_b.size() != 1 || obs_b[0][31:0] !== bw) begin errors++; $display("FAIL skew_words got=%0d/%0d exp=1/1", obs_a.size(), obs_b.size()); end
  endtask

  task automatic test_full();
    logic [31:0] pa[5];
    logic [31:0] pb[5];
    do_reset();
    for (int k = 0; k < 5; k++) begin pa[k] = $urandom; pb[k] = $urandom; end
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_a = pa[k]; in_b = pb[k]; in_last = (k == 3);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready k=%0d got=%b exp=1", k, in_ready); end
      record();
      @(negedge aclk);
    end
    in_a = pa[4]; in_b = pb[4]; in_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL full_hold cyc=%0d ready/busy got=%b%b exp=01", c, in_ready, busy); end
      record();
      @(negedge aclk);
    end
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1;
    for (int c = 0; c < 40 && npop < 5; c++) begin
      #1 record();
      @(negedge aclk);
      if (hist.size() == 5) in_valid = 1'b0;
    end
    #1;
    checks++; if (npop != 5 || hist.size() != 5) begin errors++; $display("FAIL full_drain pops=%0d pushes=%0d exp=5/5", npop, hist.size()); end
    checks++; if (pair_count !== 16'd5 || frame_count !== 16'd2) begin errors++; $display("FAIL full_counts got=%0d/%0d exp=5/2", pair_count, frame_count); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= obs_a.size() || k >= obs_b.size() || obs_a[k][31:0] !== pa[k] || obs_b[k][31:0] !== pb[k]) begin
        errors++; $display("FAIL full_order k=%0d", k);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_last = (i % 3 == 2);
      #1;
      if (i >= 1) begin
        checks++; if (pair_count !== 16'(i - 1)) begin errors++; $display("FAIL b2b_rate i=%0d got=%0d exp=%0d", i, pair_count, i - 1); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_occupancy i=%0d busy/ready got=%b%b exp=11", i, busy, in_ready); end
      end
      record();
      @(negedge aclk);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 10 && npop < hist.size(); c++) begin
      #1 record();
      @(negedge aclk);
    end
    #1;
    checks++; if (pair_count !== 16'd12 || frame_count !== 16'd4) begin errors++; $display("FAIL b2b_counts got=%0d/%0d exp=12/4", pair_count, frame_count); end
    for (int k = 0; k < hist.size(); k++) begin
      checks++;
      if (k >= obs_a.size() || k >= obs_b.size() || obs_a[k] !== {hist[k][64], hist[k][31:0]} || obs_b[k] !== {hist[k][64], hist[k][63:32]}) begin
        errors++; $display("FAIL b2b_order k=%0d", k);
      end
    end
  endtask

  task automatic test_random_stream();
    int s;
    logic [31:0] cur_a, cur_b;
    logic        sa, sb;
    logic [32:0] wa, wb;
    do_reset();
    s = 0; sa = 1'b0; sb = 1'b0; wa = '0; wb = '0;
    cur_a = $urandom; cur_b = $urandom;
    for (int c = 0; c < 600 && npop < 20; c++) begin
      m_axis_a_tready = ($urandom_range(0, 2) != 0);
      m_axis_b_tready = ($urandom_range(0, 2) != 0);
      in_valid = (s < 20) && ($urandom_range(0, 3) != 0);
      in_a = cur_a; in_b = cur_b; in_last = (s % 5 == 4);
      #1;
      if (sa) begin
        checks++; if (m_axis_a_tvalid !== 1'b1 || {m_axis_a_tlast, m_axis_a_tdata} !== wa) begin errors++; $display("FAIL stream_a_stable cyc=%0d got=%b/%h exp=1/%h", c, m_axis_a_tvalid, {m_axis_a_tlast, m_axis_a_tdata}, wa); end
      end
      if (sb) begin
        checks++; if (m_axis_b_tvalid !== 1'b1 || {m_axis_b_tlast, m_axis_b_tdata} !== wb) begin errors++; $display("FAIL stream_b_stable cyc=%0d got=%b/%h exp=1/%h", c, m_axis_b_tvalid, {m_axis_b_tlast, m_axis_b_tdata}, wb); end
      end
      sa = m_axis_a_tvalid && !m_axis_a_tready; wa = {m_axis_a_tlast, m_axis_a_tdata};
      sb = m_axis_b_tvalid && !m_axis_b_tready; wb = {m_axis_b_tlast, m_axis_b_tdata};
      if (in_valid && in_ready) begin s++; cur_a = $urandom; cur_b = $urandom; end
      record();
      @(negedge aclk);
    end
    #1;
    checks++; if (npop != 20) begin errors++; $display("FAIL stream_done pops=%0d exp=20", npop); end
    checks++; if (pair_count !== 16'd20 || frame_count !== 16'd4) begin errors++; $display("FAIL stream_counts got=%0d/%0d exp=20/4", pair_count, frame_count); end
    checks++; if (obs_a.size() != 20 || obs_b.size() != 20) begin errors++; $display("FAIL stream_words got=%0d/%0d exp=20/20", obs_a.size(), obs_b.size()); end
    for (int k = 0; k < 20 && k < obs_a.size() && k < obs_b.size(); k++) begin
      checks++;
      if (obs_a[k] !== {hist[k][64], hist[k][31:0]} || obs_b[k] !== {hist[k][64], hist[k][63:32]}) begin
        errors++; $display("FAIL stream_order k=%0d got=%h/%h exp=%h", k, obs_a[k], obs_b[k], hist[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b0;
    in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_last = 1'b1;
    #1 record();
    @(negedge aclk);
    in_valid = 1'b0;
    #1 record();
    @(negedge aclk); #1;
    checks++; if ({m_axis_a_tvalid, m_axis_b_tvalid} !== 2'b01) begin errors++; $display("FAIL mid_partial got=%b exp=01", {m_axis_a_tvalid, m_axis_b_tvalid}); end
    #2 areset = 1'b1;
    clear_model();
    #1;
    checks++; if ({m_axis_a_tvalid, m_axis_b_tvalid, busy} !== 3'b000) begin errors++; $display("FAIL mid_rst_outputs got=%b exp=000", {m_axis_a_tvalid, m_axis_b_tvalid, busy}); end
    checks++; if ({pair_count, frame_count} !== 32'd0) begin errors++; $display("FAIL mid_rst_counts got=%h exp=0", {pair_count, frame_count}); end
    @(negedge aclk);
    areset = 1'b0;
    m_axis_b_tready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({m_axis_a_tvalid, m_axis_b_tvalid, busy} !== 3'b000) begin errors++; $display("FAIL mid_no_resend cyc=%0d got=%b exp=000", c, {m_axis_a_tvalid, m_axis_b_tvalid, busy}); end
      @(negedge aclk);
    end
  endtask

  task automatic test_wrap();
    logic seen;
    do_reset();
    seen = 1'b0;
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1;
    in_valid = 1'b1; in_last = 1'b1;
    for (int c = 0; c < 70000 && npop < 65536; c++) begin
      in_a = $urandom; in_b = $urandom;
      #1;
      if (npop == 65535 && !seen) begin
        seen = 1'b1;
        checks++; if (pair_count !== 16'hFFFF || frame_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got=%h/%h exp=ffff/ffff", pair_count, frame_count); end
      end
      record();
      @(negedge aclk);
    end
    in_valid = 1'b0;
    #1;
    checks++; if (!seen || npop != 65536) begin errors++; $display("FAIL wrap_reach pops=%0d exp=65536", npop); end
    checks++; if (pair_count !== 16'h0000 || frame_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got=%h/%h exp=0000/0000", pair_count, frame_count); end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_latency();
    test_skew();
    test_full();
    test_back_to_back();
    test_random_stream();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
